// File: rtl/pcounter_cfg_target_if.sv
// Configuration bus between the pcounter initiator and the pcounter_cfg_target responder.
// Strobe semantics: an access is taken on the first cycle enable is high; rd_wr/addr/wdata are sampled then.
interface pcounter_cfg_target_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 10
) ();
  logic              enable;
  logic              rd_wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              err;

  modport master (
    output enable, rd_wr, addr, wdata,
    input  rdata, rvalid, err
  );

  modport slave (
    input  enable, rd_wr, addr, wdata,
    output rdata, rvalid, err
  );
endinterface

// File: rtl/pcounter_cfg_target.sv
// Responder for the pcounter configuration bus: control registers, the programmable
// up/down counter with saturate or auto-reload, and registered read-back.
module pcounter_cfg_target #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  pcounter_cfg_target_if.slave cfg,
  output logic [DATA_W-1:0]    counter_o,
  output logic                 wrap_o
);

  localparam logic [ADDR_W-1:0] A_CTRL  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_LOAD  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_LIMIT = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_STEP  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_WRAPS = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_COUNT = ADDR_W'(5);

  logic [2:0]        ctrl;
  logic [DATA_W-1:0] load_r;
  logic [DATA_W-1:0] limit_r;
  logic [DATA_W-1:0] step_r;
  logic [DATA_W-1:0] count_r;
  logic [DATA_W-1:0] wraps_r;

  logic              en_q;
  logic              armed;
  logic              accept;
  logic              wr_acc;
  logic              rd_acc;
  logic              wr_bad;
  logic              rd_bad;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] count_nx;
  logic              wrap_nx;
  logic [DATA_W:0]   sum_up;

  // armed stays low out of reset so a strobe left high across reset needs a fresh rising edge.
  assign accept = cfg.enable & ~en_q & armed;
  assign wr_acc = accept & ~cfg.rd_wr;
  assign rd_acc = accept & cfg.rd_wr;
  assign wr_bad = cfg.addr >= A_WRAPS;
  assign rd_bad = cfg.addr > A_COUNT;
  assign sum_up = {1'b0, count_r} + {1'b0, step_r};

  always_comb begin
    rd_mux = '0;
    case (cfg.addr)
      A_CTRL:  rd_mux = {{(DATA_W-3){1'b0}}, ctrl};
      A_LOAD:  rd_mux = load_r;
      A_LIMIT: rd_mux = limit_r;
      A_STEP:  rd_mux = step_r;
      A_WRAPS: rd_mux = wraps_r;
      A_COUNT: rd_mux = count_r;
      default: rd_mux = '0;
    endcase
  end

  // The step always uses the registers as they stood before this edge; a LOAD write overrides it.
  always_comb begin
    count_nx = count_r;
    wrap_nx  = 1'b0;
    if (wr_acc && cfg.addr == A_LOAD) begin
      count_nx = cfg.wdata;
    end else if (ctrl[0] && step_r != '0) begin
      if (!ctrl[1]) begin
        if (sum_up > {1'b0, limit_r}) begin
          if (ctrl[2]) begin
            count_nx = load_r;
            wrap_nx  = 1'b1;
          end else begin
            count_nx = limit_r;
          end
        end else begin
          count_nx = sum_up[DATA_W-1:0];
        end
      end else begin
        if (count_r < step_r) begin
          if (ctrl[2]) begin
            count_nx = limit_r;
            wrap_nx  = 1'b1;
          end else begin
            count_nx = '0;
          end
        end else begin
          count_nx = count_r - step_r;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q    <= 1'b0;
      armed   <= 1'b0;
      ctrl    <= '0;
      load_r  <= '0;
      limit_r <= '1;
      step_r  <= DATA_W'(1);
      count_r <= '0;
      wraps_r <= '0;
      wrap_o  <= 1'b0;
    end else begin
      en_q    <= cfg.enable;
      if (!cfg.enable) armed <= 1'b1;
      count_r <= count_nx;
      wrap_o  <= wrap_nx;
      if (wrap_nx && wraps_r != '1) wraps_r <= wraps_r + DATA_W'(1);
      if (wr_acc) begin
        case (cfg.addr)
          A_CTRL:  ctrl    <= cfg.wdata[2:0];
          A_LOAD:  load_r  <= cfg.wdata;
          A_LIMIT: limit_r <= cfg.wdata;
          A_STEP:  step_r  <= cfg.wdata;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg.rdata  <= '0;
      cfg.rvalid <= 1'b0;
      cfg.err    <= 1'b0;
    end else begin
      cfg.rvalid <= rd_acc;
      cfg.err    <= (wr_acc & wr_bad) | (rd_acc & rd_bad);
      if (rd_acc) cfg.rdata <= rd_mux;
    end
  end

  assign counter_o = count_r;

endmodule

// File: tb/tb_pcounter_cfg_target.sv
// Bench for pcounter_cfg_target: directed scenarios plus randomized bus traffic,
// all outputs compared every cycle against a behavioural model of the register map and counter.
module tb_pcounter_cfg_target;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 10;
  localparam int ONES   = (1 << DATA_W) - 1;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] counter_o;
  logic              wrap_o;

  pcounter_cfg_target_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cfg_bus ();

  pcounter_cfg_target #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg       (cfg_bus),
    .counter_o (counter_o),
    .wrap_o    (wrap_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int m_ctrl, m_load, m_limit, m_step, m_count, m_wraps;
  int m_rdata;
  bit m_rvalid, m_err, m_wrap;
  bit m_prev_low;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 0; m_load = 0; m_limit = ONES; m_step = 1; m_count = 0; m_wraps = 0;
    m_rdata = 0; m_rvalid = 0; m_err = 0; m_wrap = 0;
    m_prev_low = 0;
    exp_q.delete();
  endtask

  function automatic int reg_value(input int a);
    case (a)
      0: return m_ctrl;
      1: return m_load;
      2: return m_limit;
      3: return m_step;
      4: return m_wraps;
      5: return m_count;
      default: return 0;
    endcase
  endfunction

  // One rising edge of the reference: an access is taken when the strobe is high now
  // and was seen low on the previous edge; counting uses the pre-edge register values.
  task automatic model_edge();
    bit acc, up, reload;
    int a, d, nc;
    bit wr;
    if (!rst) begin
      model_reset();
      return;
    end
    acc = cfg_bus.enable && m_prev_low;
    a   = int'(cfg_bus.addr);
    d   = int'(cfg_bus.wdata);
    up     = (m_ctrl & 2) == 0;
    reload = (m_ctrl & 4) != 0;
    nc = m_count;
    wr = 0;
    if (acc && !cfg_bus.rd_wr && a == 1) nc = d;
    else if ((m_ctrl & 1) && m_step != 0) begin
      if (up) begin
        if (m_count + m_step > m_limit) begin
          if (reload) begin nc = m_load; wr = 1; end
          else nc = m_limit;
        end else nc = m_count + m_step;
      end else begin
        if (m_count < m_step) begin
          if (reload) begin nc = m_limit; wr = 1; end
          else nc = 0;
        end else nc = m_count - m_step;
      end
    end
    m_rvalid = 0;
    m_err    = 0;
    if (acc && cfg_bus.rd_wr) begin
      exp_q.push_back(DATA_W'(reg_value(a)));
      m_rvalid = 1;
      m_err    = (a >= 6);
    end
    if (acc && !cfg_bus.rd_wr) begin
      case (a)
        0: m_ctrl  = d & 7;
        1: m_load  = d;
        2: m_limit = d;
        3: m_step  = d;
        default: m_err = 1;
      endcase
    end
    if (wr && m_wraps < ONES) m_wraps++;
    m_count    = nc;
    m_wrap     = wr;
    m_prev_low = !cfg_bus.enable;
  endtask

  task automatic check_all();
    check("counter", 32'(counter_o), 32'(m_count));
    check("wrap", 32'(wrap_o), 32'(m_wrap));
    check("rvalid", 32'(cfg_bus.rvalid), 32'(m_rvalid));
    check("err", 32'(cfg_bus.err), 32'(m_err));
    if (m_rvalid) begin
      if (exp_q.size() == 0) check("rd_queue", 32'(1), 32'(0));
      else m_rdata = int'(exp_q.pop_front());
    end
    check("rdata", 32'(cfg_bus.rdata), 32'(m_rdata));
  endtask

  // driver tasks
  task automatic cycle(input bit e, input bit rw, input int a, input int d);
    @(negedge clk);
    cfg_bus.enable = e;
    cfg_bus.rd_wr  = rw;
    cfg_bus.addr   = ADDR_W'(a);
    cfg_bus.wdata  = DATA_W'(d);
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    cycle(0, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, ONES));
  endtask

  task automatic access(input bit rw, input int a, input int d, input int hold);
    for (int i = 0; i < hold; i++) cycle(1, rw, a, d);
    idle();
  endtask

  task automatic idle_expect(input int cnt);
    idle();
    check("seq_counter", 32'(counter_o), 32'(cnt));
  endtask

  task automatic mid_reset(input bit strobe);
    @(negedge clk);
    cfg_bus.enable = strobe;
    cfg_bus.rd_wr  = 1'b0;
    cfg_bus.addr   = '0;
    cfg_bus.wdata  = DATA_W'(1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_async_counter", 32'(counter_o), 32'(0));
    check("rst_async_outs", {29'(0), wrap_o, cfg_bus.rvalid, cfg_bus.err}, 32'(0));
    check_all();
    cycle(strobe, 0, 0, 1);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    cfg_bus.enable = 1'b0;
    cfg_bus.rd_wr  = 1'b0;
    cfg_bus.addr   = '0;
    cfg_bus.wdata  = '0;
    model_reset();
    cycle(0, 0, 0, 0);
    check("reset_rdata", 32'(cfg_bus.rdata), 32'(0));
    #2;
    rst = 1'b1;
    idle();

    // enable, strobe held two cycles: one write, count +1 per cycle
    access(0, 0, 1, 2);
    idle_expect(3);
    idle_expect(4);
    check("no_err", 32'(cfg_bus.err), 32'(0));

    // step becomes 3 the cycle after acceptance
    access(0, 3, 3, 1);
    idle_expect(11);
    idle_expect(14);

    // auto-reload: 2, 5, 8, 2, 5 ...
    access(0, 0, 0, 1);
    access(0, 2, 10, 1);
    access(0, 1, 2, 1);
    access(0, 0, 5, 1);
    idle_expect(8);
    idle_expect(2);
    check("reload_wrap", 32'(wrap_o), 32'(1));
    idle_expect(5);
    idle_expect(8);
    idle_expect(2);
    access(1, 4, 0, 1);
    check("wraps_read", 32'(cfg_bus.rdata), 32'(2));

    // down, no reload: 5, 3, 1, 0, 0
    access(0, 3, 2, 1);
    access(0, 0, 3, 1);
    access(0, 1, 5, 1);
    idle_expect(1);
    idle_expect(0);
    idle_expect(0);

    // read-only and unmapped addresses
    access(0, 5, 'h3FF, 1);
    access(1, 7, 0, 1);
    check("unmapped_rdata", 32'(cfg_bus.rdata), 32'(0));
    access(0, 6, 'h155, 2);
    access(1, 5, 0, 1);

    // reset mid-count with strobe high
    access(0, 0, 0, 1);
    access(0, 2, ONES, 1);
    access(0, 1, 'hA0, 1);
    access(1, 5, 0, 1);
    check("pre_reset_count", 32'(cfg_bus.rdata), 32'('hA0));
    mid_reset(1'b1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1);
    check("strobe_held_no_access", 32'(counter_o), 32'(0));
    idle();
    access(0, 0, 1, 1);
    idle_expect(2);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int a, d;
      a = $urandom_range(0, 7);
      d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, ONES) : $urandom_range(0, 24);
      if ($urandom_range(0, 59) == 0) mid_reset(1'($urandom_range(0, 1)));
      access(1'($urandom_range(0, 1)), a, d, $urandom_range(1, 3));
      if ($urandom_range(0, 2) == 0) idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
